// File: rtl/msi_snoop_arbiter.sv
// Shared-bus MSI coherence arbiter for two cache controllers: serialises snoop, invalidate
// and memory-port traffic with round-robin fairness between core 0 and core 1.
module msi_snoop_arbiter #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_miss0,
    input  logic              read_miss1,
    input  logic              write_miss0,
    input  logic              write_miss1,
    input  logic              invalidate0,
    input  logic              invalidate1,
    input  logic [ADDR_W-1:0] BICO0,
    input  logic [ADDR_W-1:0] BICO1,
    input  logic              mem_req0,
    input  logic              mem_req1,
    input  logic              cpu_search_found0,
    input  logic              cpu_search_found1,
    input  logic [DATA_W-1:0] send_other_proc_data0,
    input  logic [DATA_W-1:0] send_other_proc_data1,
    input  logic              u_rdy,
    output logic              grant0,
    output logic              grant1,
    output logic [1:0]        cpu_datasel0,
    output logic [1:0]        cpu_datasel1,
    output logic [DATA_W-1:0] other_proc_data0,
    output logic [DATA_W-1:0] other_proc_data1,
    output logic              cpu_search0,
    output logic              cpu_search1,
    output logic [ADDR_W-1:0] BOCI0,
    output logic [ADDR_W-1:0] BOCI1,
    output logic              invalidate_from_other_cpu0,
    output logic              invalidate_from_other_cpu1
);

    typedef enum logic [2:0] {StIdle, StSnoop, StXfer, StMemFill, StInv, StMemBus} state_e;

    state_e            state_q, state_d;
    logic [1:0]        pend_q;
    logic [1:0]        inv_q;
    logic [ADDR_W-1:0] addr_q [2];
    logic [ADDR_W-1:0] boci_q [2];
    logic [ADDR_W-1:0] boci_d [2];
    logic [DATA_W-1:0] data_q, data_d;
    logic              cur_q, cur_d;
    logic              rr_q, rr_d;

    logic [1:0]        rm, wm, iv, mreq, found;
    logic [1:0]        cap, req, req_inv, clr;
    logic [ADDR_W-1:0] bico [2];
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] sdata [2];
    logic              coh_pick, mem_pick;

    logic [1:0]        grant, search, inv_out;
    logic [1:0]        dsel [2];
    logic [DATA_W-1:0] fwd [2];

    assign rm       = {read_miss1, read_miss0};
    assign wm       = {write_miss1, write_miss0};
    assign iv       = {invalidate1, invalidate0};
    assign mreq     = {mem_req1, mem_req0};
    assign found    = {cpu_search_found1, cpu_search_found0};
    assign bico[0]  = BICO0;
    assign bico[1]  = BICO1;
    assign sdata[0] = send_other_proc_data0;
    assign sdata[1] = send_other_proc_data1;

    // A pulse arriving this cycle is visible to arbitration immediately, so an uncontended
    // request leaves IDLE on the same edge that records it.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            cap[n]      = (rm[n] | wm[n] | iv[n]) & ~pend_q[n];
            req[n]      = pend_q[n] | cap[n];
            req_inv[n]  = cap[n] ? (wm[n] | iv[n]) : inv_q[n];
            req_addr[n] = cap[n] ? bico[n] : addr_q[n];
        end
        coh_pick = (req == 2'b11) ? ~rr_q : req[1];
        mem_pick = (mreq == 2'b11) ? ~rr_q : mreq[1];
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        data_d  = data_q;
        clr     = 2'b00;
        boci_d  = boci_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    cur_d                 = coh_pick;
                    rr_d                  = coh_pick;
                    boci_d[~coh_pick]     = req_addr[coh_pick];
                    state_d               = req_inv[coh_pick] ? StInv : StSnoop;
                end else if (|mreq) begin
                    cur_d   = mem_pick;
                    rr_d    = mem_pick;
                    state_d = StMemBus;
                end
            end
            StSnoop: begin
                data_d  = sdata[~cur_q];
                state_d = found[~cur_q] ? StXfer : StMemFill;
            end
            StXfer: begin
                clr[cur_q] = 1'b1;
                state_d    = StIdle;
            end
            StMemFill: begin
                if (u_rdy) begin
                    clr[cur_q] = 1'b1;
                    state_d    = StIdle;
                end
            end
            StInv: begin
                clr[cur_q] = 1'b1;
                state_d    = StIdle;
            end
            StMemBus: begin
                if (!mreq[cur_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant   = 2'b00;
        search  = 2'b00;
        inv_out = 2'b00;
        dsel[0] = 2'b00;
        dsel[1] = 2'b00;
        fwd[0]  = '0;
        fwd[1]  = '0;
        unique case (state_q)
            StIdle: ;
            StSnoop: search[~cur_q] = 1'b1;
            StXfer: begin
                grant[cur_q] = 1'b1;
                dsel[cur_q]  = 2'b01;
                fwd[cur_q]   = data_q;
            end
            StMemFill: grant[cur_q] = 1'b1;
            StInv: begin
                grant[cur_q]    = 1'b1;
                inv_out[~cur_q] = 1'b1;
            end
            // Grant follows mem_req directly so it drops in the release cycle.
            StMemBus: grant[cur_q] = mreq[cur_q];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pend_q  <= 2'b00;
            inv_q   <= 2'b00;
            cur_q   <= 1'b0;
            rr_q    <= 1'b0;
            data_q  <= '0;
            for (int n = 0; n < 2; n++) begin
                addr_q[n] <= '0;
                boci_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            for (int n = 0; n < 2; n++) begin
                pend_q[n] <= ~clr[n] & req[n];
                inv_q[n]  <= req_inv[n];
                addr_q[n] <= req_addr[n];
                boci_q[n] <= boci_d[n];
            end
        end
    end

    assign grant0                     = grant[0];
    assign grant1                     = grant[1];
    assign cpu_datasel0               = dsel[0];
    assign cpu_datasel1               = dsel[1];
    assign other_proc_data0           = fwd[0];
    assign other_proc_data1           = fwd[1];
    assign cpu_search0                = search[0];
    assign cpu_search1                = search[1];
    assign BOCI0                      = boci_q[0];
    assign BOCI1                      = boci_q[1];
    assign invalidate_from_other_cpu0 = inv_out[0];
    assign invalidate_from_other_cpu1 = inv_out[1];

endmodule

// File: tb/tb_msi_snoop_arbiter.sv
// Scoreboard bench for msi_snoop_arbiter: stimulus pushes the expected sequence of active bus
// cycles, a negedge monitor pops one entry for every cycle in which the DUT strobes anything.
module tb_msi_snoop_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    rm, wm, iv, mreq, fnd;
    logic [AW-1:0] bico [2];
    logic [DW-1:0] sdata [2];
    logic          u_rdy;

    logic          grant0, grant1, cs0, cs1, inv0, inv1;
    logic [1:0]    ds0, ds1;
    logic [DW-1:0] opd0, opd1;
    logic [AW-1:0] boci0, boci1;
    logic [1:0]    grant_v, cs_v, inv_v;

    assign grant_v = {grant1, grant0};
    assign cs_v    = {cs1, cs0};
    assign inv_v   = {inv1, inv0};

    always #5 clk = ~clk;

    msi_snoop_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_miss0(rm[0]), .read_miss1(rm[1]),
        .write_miss0(wm[0]), .write_miss1(wm[1]),
        .invalidate0(iv[0]), .invalidate1(iv[1]),
        .BICO0(bico[0]), .BICO1(bico[1]),
        .mem_req0(mreq[0]), .mem_req1(mreq[1]),
        .cpu_search_found0(fnd[0]), .cpu_search_found1(fnd[1]),
        .send_other_proc_data0(sdata[0]), .send_other_proc_data1(sdata[1]),
        .u_rdy(u_rdy),
        .grant0(grant0), .grant1(grant1),
        .cpu_datasel0(ds0), .cpu_datasel1(ds1),
        .other_proc_data0(opd0), .other_proc_data1(opd1),
        .cpu_search0(cs0), .cpu_search1(cs1),
        .BOCI0(boci0), .BOCI1(boci1),
        .invalidate_from_other_cpu0(inv0), .invalidate_from_other_cpu1(inv1)
    );

    typedef struct {
        logic [1:0]    grant;
        logic [1:0]    cs;
        logic [1:0]    inv;
        logic [1:0]    ds [2];
        logic [DW-1:0] opd [2];
        logic [AW-1:0] boci [2];
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mdl_rr;   // core that was served last; the other core wins the next tie

    function automatic rec_t blank();
        rec_t r;
        r.grant = 2'b00; r.cs = 2'b00; r.inv = 2'b00;
        for (int n = 0; n < 2; n++) begin
            r.ds[n] = 2'b00; r.opd[n] = '0; r.boci[n] = '0;
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [31:0] v;
        v = $urandom;
        return v[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [31:0] v;
        v = $urandom;
        return v[DW-1:0];
    endfunction

    // Expected bus activity for one served coherence request from core c.
    task automatic push_req(input logic c, input logic is_inv, input logic [AW-1:0] a,
                            input logic hit, input logic [DW-1:0] d, input int k);
        rec_t r;
        r = blank();
        if (is_inv) begin
            r.grant[c] = 1'b1; r.inv[~c] = 1'b1; r.boci[~c] = a;
            exp_q.push_back(r);
        end else begin
            r.cs[~c] = 1'b1; r.boci[~c] = a;
            exp_q.push_back(r);
            r = blank();
            r.grant[c] = 1'b1;
            if (hit) begin
                r.ds[c] = 2'b01; r.opd[c] = d;
                exp_q.push_back(r);
            end else begin
                repeat (k + 1) exp_q.push_back(r);
            end
        end
        mdl_rr = c;
    endtask

    always @(negedge clk) begin : monitor
        rec_t r;
        logic bad;
        if (rst_n) begin
            checks++;
            if (grant0 && grant1) begin
                errors++;
                $display("FAIL one_grant got %b want at most one bit", grant_v);
            end
            if ((grant_v | cs_v | inv_v) != 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_activity t=%0t grant=%b cs=%b inv=%b want idle",
                             $time, grant_v, cs_v, inv_v);
                end else begin
                    r = exp_q.pop_front();
                    bad = (grant_v != r.grant) || (cs_v != r.cs) || (inv_v != r.inv) ||
                          (ds0 != r.ds[0]) || (ds1 != r.ds[1]);
                    if (r.ds[0] == 2'b01 && opd0 != r.opd[0]) bad = 1'b1;
                    if (r.ds[1] == 2'b01 && opd1 != r.opd[1]) bad = 1'b1;
                    if ((r.cs[0] || r.inv[0]) && boci0 != r.boci[0]) bad = 1'b1;
                    if ((r.cs[1] || r.inv[1]) && boci1 != r.boci[1]) bad = 1'b1;
                    if (bad) begin
                        errors++;
                        $display({"FAIL bus_cycle t=%0t got g=%b cs=%b inv=%b ds=%b,%b ",
                                  "opd=%h,%h boci=%h,%h want g=%b cs=%b inv=%b ds=%b,%b ",
                                  "opd=%h,%h boci=%h,%h"}, $time, grant_v, cs_v, inv_v,
                                 ds0, ds1, opd0, opd1, boci0, boci1, r.grant, r.cs, r.inv,
                                 r.ds[0], r.ds[1], r.opd[0], r.opd[1], r.boci[0], r.boci[1]);
                    end
                end
            end else begin
                checks++;
                if (ds0 != 2'b00 || ds1 != 2'b00) begin
                    errors++;
                    $display("FAIL idle_datasel got %b,%b want 00,00", ds0, ds1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        rm = 2'b00; wm = 2'b00; iv = 2'b00;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        logic [127:0] all;
        all = {grant1, grant0, ds1, ds0, opd1, opd0, cs1, cs0, boci1, boci0, inv1, inv0};
        checks++;
        if (all != '0) begin
            errors++;
            $display("FAIL %s outputs got %h want 0", name, all);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain timeout got %0d entries left want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        rst_n = 1'b1;
        mdl_rr = 1'b0;
        tick();
    endtask

    // Uncontended read miss: snoop at T+1, grant at T+2, k not-ready cycles on a miss.
    task automatic sc_read(input logic c, input logic [AW-1:0] a, input logic hit,
                           input logic [DW-1:0] d, input int k);
        fnd[~c] = hit; sdata[~c] = d; u_rdy = 1'b0;
        push_req(c, 1'b0, a, hit, d, k);
        bico[c] = a; rm[c] = 1'b1;
        tick();
        clear_pulses();
        check_bit("snoop_latency", cs_v[~c], 1'b1);
        tick();
        check_bit("grant_latency", grant_v[c], 1'b1);
        repeat (k) tick();
        u_rdy = 1'b1;
        tick();
        drain();
    endtask

    task automatic sc_inv(input logic c, input logic [AW-1:0] a, input logic w,
                          input logic i, input logic r);
        push_req(c, 1'b1, a, 1'b0, '0, 0);
        bico[c] = a; wm[c] = w; iv[c] = i; rm[c] = r;
        tick();
        clear_pulses();
        check_bit("inv_latency", inv_v[~c] & grant_v[c], 1'b1);
        drain();
    endtask

    task automatic sc_pair(input logic [1:0] ty);
        logic [AW-1:0] a [2];
        logic          first;
        u_rdy = 1'b1;
        for (int n = 0; n < 2; n++) begin
            a[n] = rand_addr(); fnd[n] = ($urandom_range(0, 1) == 1); sdata[n] = rand_data();
        end
        first = ~mdl_rr;
        push_req(first, ty[first], a[first], fnd[~first], sdata[~first], 0);
        push_req(~first, ty[~first], a[~first], fnd[first], sdata[first], 0);
        for (int n = 0; n < 2; n++) begin
            bico[n] = a[n];
            if (ty[n]) begin
                wm[n] = ($urandom_range(0, 1) == 1);
                iv[n] = ~wm[n] | ($urandom_range(0, 1) == 1);
                rm[n] = ($urandom_range(0, 1) == 1);
            end else begin
                rm[n] = 1'b1;
            end
        end
        tick();
        clear_pulses();
        drain();
    endtask

    // Core ~c pulses while it is being snooped; it must be served right after.
    task automatic sc_snooped(input logic c);
        logic [AW-1:0] ac, ao;
        ac = rand_addr(); ao = rand_addr(); u_rdy = 1'b1;
        fnd = 2'($urandom_range(0, 3)); sdata[0] = rand_data(); sdata[1] = rand_data();
        push_req(c, 1'b0, ac, fnd[~c], sdata[~c], 0);
        push_req(~c, 1'b0, ao, fnd[c], sdata[c], 0);
        bico[c] = ac; rm[c] = 1'b1;
        tick();
        clear_pulses();
        bico[~c] = ao; rm[~c] = 1'b1;
        tick();
        clear_pulses();
        drain();
    endtask

    // mem_req held for len cycles: one IDLE arbitration cycle, then grant while it stays high.
    task automatic sc_mem(input logic c, input int len);
        rec_t r;
        r = blank();
        r.grant[c] = 1'b1;
        repeat (len - 1) exp_q.push_back(r);
        mdl_rr = c;
        mreq[c] = 1'b1;
        repeat (len) tick();
        mreq[c] = 1'b0;
        drain();
    endtask

    initial begin : stimulus
        int            kind, nw;
        logic          c, w, i;
        logic [AW-1:0] a;
        rec_t          r;

        clear_pulses();
        mreq = 2'b00; fnd = 2'b00; u_rdy = 1'b1;
        bico[0] = '0; bico[1] = '0; sdata[0] = '0; sdata[1] = '0;
        mdl_rr = 1'b0;
        do_reset();

        sc_read(1'b0, 13'h0A4, 1'b1, 16'hBEEF, 0);
        sc_read(1'b1, 13'h155, 1'b0, 16'h0000, 3);
        sc_inv(1'b0, 13'h1F0, 1'b0, 1'b1, 1'b0);

        do_reset();
        sc_pair(2'b00);
        sc_pair(2'b00);

        // mem_req0 for 5 cycles with a read_miss1 arriving mid-burst.
        a = 13'h0777; fnd[0] = 1'b1; sdata[0] = 16'h1234; u_rdy = 1'b1;
        r = blank();
        r.grant[0] = 1'b1;
        repeat (4) exp_q.push_back(r);
        push_req(1'b1, 1'b0, a, 1'b1, 16'h1234, 0);
        mreq[0] = 1'b1;
        tick();
        bico[1] = a; rm[1] = 1'b1;
        tick();
        clear_pulses();
        repeat (3) tick();
        mreq[0] = 1'b0;
        drain();

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 4);
            c = ($urandom_range(0, 1) == 1);
            case (kind)
                0: sc_read(c, rand_addr(), ($urandom_range(0, 1) == 1), rand_data(),
                           $urandom_range(0, 4));
                1: begin
                    w = ($urandom_range(0, 1) == 1);
                    i = ~w | ($urandom_range(0, 1) == 1);
                    sc_inv(c, rand_addr(), w, i, ($urandom_range(0, 1) == 1));
                end
                2: sc_pair(2'($urandom_range(0, 3)));
                3: sc_mem(c, $urandom_range(1, 6));
                default: sc_snooped(c);
            endcase
        end

        // Asynchronous reset while core 1 waits in the memory fill; core 0 is left pending.
        a = 13'h0ABC; fnd[0] = 1'b0; u_rdy = 1'b0;
        push_req(1'b1, 1'b0, a, 1'b0, '0, 0);
        bico[1] = a; rm[1] = 1'b1;
        tick();
        clear_pulses();
        bico[0] = 13'h0321; rm[0] = 1'b1;
        tick();
        clear_pulses();
        nw = 0;
        while (exp_q.size() != 0 && nw < 20) begin
            @(negedge clk);
            #1;
            nw++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fill_before_reset got %0d entries left want 0", exp_q.size());
            exp_q.delete();
        end
        check_bit("grant1_before_reset", grant1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (3) tick();
        u_rdy = 1'b1;
        mdl_rr = 1'b0;
        rst_n = 1'b1;
        repeat (12) tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
